// File: rtl/prog_rom_sched_if.sv
// Bus between the program-ROM scheduler and its surroundings:
// the ROM port, the decode-side instruction queue head and the table-read port.
interface prog_rom_sched_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              tbl_req;
    logic [ADDR_W-1:0] tbl_addr;
    logic              tbl_done;
    logic [DATA_W-1:0] tbl_data;

    // slave is the scheduler; master is the ROM/decode/execute side
    modport slave (
        output rom_addr, instr_valid, instr, instr_pc, tbl_done, tbl_data,
        input  rom_data, instr_ready, redirect, redirect_pc, tbl_req, tbl_addr
    );
    modport master (
        input  rom_addr, instr_valid, instr, instr_pc, tbl_done, tbl_data,
        output rom_data, instr_ready, redirect, redirect_pc, tbl_req, tbl_addr
    );
endinterface

// File: rtl/prog_rom_sched.sv
// Program-ROM access scheduler: shares the single ROM address port between
// the instruction prefetch queue and the table-read port, one access per cycle.
module prog_rom_sched #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input logic              clk,
    input logic              rst_n,
    prog_rom_sched_if.slave  bus
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    typedef enum logic {GNT_TBL, GNT_FETCH} gnt_e;

    entry_t [QDEPTH-1:0] q, q_nxt;
    logic [CNT_W-1:0]    count, wr_idx;
    logic [ADDR_W-1:0]   fetch_pc;
    gnt_e                last_gnt;
    logic                tbl_done_q;
    logic [DATA_W-1:0]   tbl_data_q;

    logic pop, q_full, fetch_want, gnt_tbl, gnt_fetch;

    assign pop        = (count != '0) & bus.instr_ready;
    assign q_full     = (count == CNT_W'(QDEPTH));
    assign fetch_want = ~bus.redirect & (~q_full | pop);
    // Table reads win unless the queue is empty; then the last loser goes first.
    assign gnt_tbl    = bus.tbl_req & (~fetch_want | (count != '0) | (last_gnt == GNT_FETCH));
    assign gnt_fetch  = ~gnt_tbl & fetch_want;
    assign wr_idx     = count - CNT_W'(pop);

    assign bus.rom_addr    = gnt_tbl ? bus.tbl_addr : fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = q[0].word;
    assign bus.instr_pc    = q[0].pc;
    assign bus.tbl_done    = tbl_done_q;
    assign bus.tbl_data    = tbl_data_q;

    // Head-at-zero shift queue; slots past count are kept zero so an empty
    // queue presents zero on instr/instr_pc without extra masking.
    always_comb begin
        q_nxt = q;
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) q_nxt[i] = q[i+1];
            q_nxt[QDEPTH-1] = '0;
        end
        if (gnt_fetch) begin
            for (int i = 0; i < QDEPTH; i++)
                if (CNT_W'(i) == wr_idx) q_nxt[i] = '{pc: fetch_pc, word: bus.rom_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q          <= '0;
            count      <= '0;
            fetch_pc   <= RESET_PC;
            last_gnt   <= GNT_TBL;
            tbl_done_q <= 1'b0;
            tbl_data_q <= '0;
        end else begin
            tbl_done_q <= gnt_tbl;
            if (gnt_tbl) tbl_data_q <= bus.rom_data;

            if (gnt_tbl)        last_gnt <= GNT_TBL;
            else if (gnt_fetch) last_gnt <= GNT_FETCH;

            if (bus.redirect) begin
                q        <= '0;
                count    <= '0;
                fetch_pc <= bus.redirect_pc;
            end else begin
                q     <= q_nxt;
                count <= count + CNT_W'(gnt_fetch) - CNT_W'(pop);
                if (gnt_fetch) fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_prog_rom_sched.sv
// Bench for prog_rom_sched: directed scenarios then random traffic, all
// checked against a queue-based reference model of the scheduler.
module tb_prog_rom_sched;
    localparam int AW = 10;
    localparam int DW = 14;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_rom_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    prog_rom_sched #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0), .QDEPTH(QD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] rom [1024];
    assign bus.rom_data = rom[bus.rom_addr];

    typedef struct {
        int pc;
        int word;
    } ent_t;

    ent_t mq[$];
    int   m_pc = 0;
    bit   m_last_fetch = 1'b0;
    int   m_done = 0;
    int   m_data = 0;
    bit   m_init = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict grant from model state, step model at the edge, compare.
    task automatic cycle();
        int sz, taddr;
        bit pop, want, tg, fg;
        #1;
        sz    = mq.size();
        pop   = (sz > 0) && bus.instr_ready;
        want  = !bus.redirect && ((sz < QD) || pop);
        tg    = bus.tbl_req && (!want || (sz != 0) || m_last_fetch);
        fg    = !tg && want;
        taddr = int'(bus.tbl_addr);
        if (rst_n && m_init) check("rom_addr", 32'(bus.rom_addr), tg ? taddr : m_pc);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_pc = 0; m_last_fetch = 1'b0; m_done = 0; m_data = 0; m_init = 1'b1;
        end else begin
            m_done = tg ? 1 : 0;
            if (tg) m_data = int'(rom[taddr]);
            if (tg) m_last_fetch = 1'b0;
            else if (fg) m_last_fetch = 1'b1;
            if (bus.redirect) begin
                mq.delete();
                m_pc = int'(bus.redirect_pc);
            end else begin
                if (pop) void'(mq.pop_front());
                if (fg) begin
                    mq.push_back('{m_pc, int'(rom[m_pc])});
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end
        #1;
        if (m_init) begin
            check("instr_valid", 32'(bus.instr_valid), (mq.size() > 0) ? 1 : 0);
            check("instr",       32'(bus.instr),    (mq.size() > 0) ? mq[0].word : 0);
            check("instr_pc",    32'(bus.instr_pc), (mq.size() > 0) ? mq[0].pc : 0);
            check("tbl_done",    32'(bus.tbl_done), m_done);
            check("tbl_data",    32'(bus.tbl_data), m_data);
        end
        @(negedge clk);
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 1024; i++) rom[i] = DW'($urandom);
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.tbl_req     = 1'b0;
        bus.tbl_addr    = '0;
        @(negedge clk);

        // reset, then streaming fetch with ready held high
        repeat (2) cycle();
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_done",  32'(bus.tbl_done), 0);
        rst_n = 1'b1;
        cycle();
        check("first_valid", 32'(bus.instr_valid), 1);
        check("first_pc",    32'(bus.instr_pc), 0);
        repeat (6) cycle();

        // stall decode from reset: queue holds pc 0,1 and fetch waits at 2
        rst_n = 1'b0; bus.instr_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        check("stall_rom_addr", 32'(bus.rom_addr), 2);
        check("stall_head_pc",  32'(bus.instr_pc), 0);
        bus.instr_ready = 1'b1;
        repeat (4) cycle();

        // redirect to the top of ROM with a full queue, then wrap
        bus.instr_ready = 1'b0;
        repeat (2) cycle();
        bus.redirect = 1'b1; bus.redirect_pc = 10'h3FF;
        cycle();
        check("redir_flush", 32'(bus.instr_valid), 0);
        bus.redirect = 1'b0;
        cycle();
        check("redir_pc", 32'(bus.instr_pc), 32'h3FF);
        bus.instr_ready = 1'b1;
        cycle();
        check("redir_wrap_pc", 32'(bus.instr_pc), 0);

        // table read while the queue is non-empty
        bus.tbl_req = 1'b1; bus.tbl_addr = 10'h010;
        cycle();
        check("tbl_done_pulse", 32'(bus.tbl_done), 1);
        check("tbl_data_010",   32'(bus.tbl_data), 32'(rom[16]));
        bus.tbl_req = 1'b0;

        // held table request against an empty queue: grants alternate
        bus.redirect = 1'b1; bus.redirect_pc = 10'h100;
        cycle();
        bus.redirect = 1'b0; bus.tbl_req = 1'b1; bus.tbl_addr = 10'h020;
        dones = 0;
        repeat (8) begin
            cycle();
            dones += int'(bus.tbl_done);
        end
        check("alt_done_count", 32'(dones), 4);

        // reset mid-stream with a table read pending
        rst_n = 1'b0;
        cycle();
        check("mid_rst_valid", 32'(bus.instr_valid), 0);
        check("mid_rst_done",  32'(bus.tbl_done), 0);
        check("mid_rst_data",  32'(bus.tbl_data), 0);
        rst_n = 1'b1; bus.tbl_req = 1'b0;
        cycle();
        check("restart_pc", 32'(bus.instr_pc), 0);

        // random traffic obeying the table-request handshake
        repeat (800) begin
            rst_n           = ($urandom_range(0, 99) != 0);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = AW'($urandom);
            if (!bus.tbl_req || m_done != 0) begin
                bus.tbl_req  = ($urandom_range(0, 2) == 0);
                bus.tbl_addr = AW'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
